issue_queue_param: RTL and testbench

//  Parametrised unified issue queue with in-order retire. Sits between rename/dispatch and the

---
 rtl/issue_queue_param.sv | 213 +++++++++++++++++++++
 tb/tb_issue_queue_param.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_param.sv
// issue_queue_param: age-ordered unified issue queue with tag wakeup, per-class oldest-first select and in-order retire.
// Define IQ_DISPATCH_WAKE_EN to let same-cycle writeback tags wake sources being dispatched.
module issue_queue_param #(
    parameter int DEPTH   = 16,
    parameter int DISP_W  = 2,
    parameter int NUM_WB  = 3,
    parameter int NUM_ISS = 3,
    parameter int RET_W   = 2,
    parameter int TAG_W   = 6,
    parameter int CLS_W   = 4,
    parameter int PAY_W   = 64,
    parameter logic [NUM_ISS*CLS_W-1:0] ISS_CLS = {4'b0001, 4'b0001, 4'b0010},
    localparam int IW = $clog2(DEPTH),
    localparam int PW = IW + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [DISP_W-1:0]         disp_valid,
    input  logic [DISP_W*CLS_W-1:0]   disp_cls,
    input  logic [DISP_W*TAG_W-1:0]   disp_src1,
    input  logic [DISP_W*TAG_W-1:0]   disp_src2,
    input  logic [DISP_W-1:0]         disp_rdy1,
    input  logic [DISP_W-1:0]         disp_rdy2,
    input  logic [DISP_W*TAG_W-1:0]   disp_dst,
    input  logic [DISP_W*PAY_W-1:0]   disp_pay,
    output logic                      disp_ready,
    output logic [DISP_W*IW-1:0]      disp_idx,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]   wb_tag,
    input  logic [NUM_WB*IW-1:0]      wb_idx,
    output logic [NUM_ISS-1:0]        iss_valid,
    input  logic [NUM_ISS-1:0]        iss_ready,
    output logic [NUM_ISS*IW-1:0]     iss_idx,
    output logic [NUM_ISS*TAG_W-1:0]  iss_src1,
    output logic [NUM_ISS*TAG_W-1:0]  iss_src2,
    output logic [NUM_ISS*TAG_W-1:0]  iss_dst,
    output logic [NUM_ISS*PAY_W-1:0]  iss_pay,
    output logic [RET_W-1:0]          ret_valid,
    output logic [RET_W*TAG_W-1:0]    ret_dst,
    output logic [RET_W*PAY_W-1:0]    ret_pay,
    output logic [PW-1:0]             count
);
    logic [PW-1:0]      head, tail, n_acc, n_ret;
    logic [DEPTH-1:0]   e_valid, e_rdy1, e_rdy2, e_sel, e_done;
    logic [CLS_W-1:0]   e_cls  [DEPTH];
    logic [TAG_W-1:0]   e_src1 [DEPTH];
    logic [TAG_W-1:0]   e_src2 [DEPTH];
    logic [TAG_W-1:0]   e_dst  [DEPTH];
    logic [PAY_W-1:0]   e_pay  [DEPTH];
    logic [DEPTH-1:0]   wk1, wk2, taken;
    logic [DISP_W-1:0]  d_acc, d_rdy1, d_rdy2;
    logic [IW-1:0]      d_idx [DISP_W];
    logic [IW-1:0]      r_idx [RET_W];
    logic [IW-1:0]      p_idx [NUM_ISS];
    logic [IW-1:0]      s_idx;
    logic [NUM_ISS-1:0] p_vld, stall;
    logic               run;

    function automatic logic wb_hit(input logic [TAG_W-1:0] t, input logic [NUM_WB-1:0] v,
                                    input logic [NUM_WB*TAG_W-1:0] tags);
        wb_hit = 1'b0;
        for (int w = 0; w < NUM_WB; w++)
            wb_hit |= v[w] && tags[w*TAG_W +: TAG_W] == t;
    endfunction

    assign count      = tail - head;
    assign disp_ready = count <= PW'(DEPTH - DISP_W);

    always_comb begin
        n_acc = '0;
        for (int k = 0; k < DISP_W; k++) begin
            d_acc[k] = disp_valid[k] & disp_ready;
            d_idx[k] = tail[IW-1:0] + IW'(k);
            disp_idx[k*IW +: IW] = d_idx[k];
            n_acc += PW'(d_acc[k]);
`ifdef IQ_DISPATCH_WAKE_EN
            d_rdy1[k] = disp_rdy1[k] | wb_hit(disp_src1[k*TAG_W +: TAG_W], wb_valid, wb_tag);
            d_rdy2[k] = disp_rdy2[k] | wb_hit(disp_src2[k*TAG_W +: TAG_W], wb_valid, wb_tag);
`else
            d_rdy1[k] = disp_rdy1[k];
            d_rdy2[k] = disp_rdy2[k];
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk1[i] = wb_hit(e_src1[i], wb_valid, wb_tag);
            wk2[i] = wb_hit(e_src2[i], wb_valid, wb_tag);
        end
    end

    // Retire lanes form a contiguous run of completed entries starting at head.
    always_comb begin
        run   = 1'b1;
        n_ret = '0;
        for (int k = 0; k < RET_W; k++) begin
            r_idx[k] = head[IW-1:0] + IW'(k);
            run &= e_valid[r_idx[k]] & e_done[r_idx[k]];
            ret_valid[k] = run;
            ret_dst[k*TAG_W +: TAG_W] = e_dst[r_idx[k]];
            ret_pay[k*PAY_W +: PAY_W] = e_pay[r_idx[k]];
            n_ret += PW'(run);
        end
    end

    // Port 0 takes the leftmost class mask of ISS_CLS; lower ports claim entries first.
    always_comb begin
        taken = '0;
        p_vld = '0;
        s_idx = '0;
        for (int p = 0; p < NUM_ISS; p++) begin
            p_idx[p] = '0;
            stall[p] = iss_valid[p] & ~iss_ready[p];
            for (int a = 0; a < DEPTH; a++) begin
                s_idx = head[IW-1:0] + IW'(a);
                if (!stall[p] && !p_vld[p] && e_valid[s_idx] && e_rdy1[s_idx] && e_rdy2[s_idx] &&
                    !e_sel[s_idx] && !taken[s_idx] &&
                    |(e_cls[s_idx] & ISS_CLS[(NUM_ISS-1-p)*CLS_W +: CLS_W])) begin
                    p_vld[p] = 1'b1;
                    p_idx[p] = s_idx;
                end
            end
            if (p_vld[p])
                taken[p_idx[p]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            e_valid   <= '0;
            e_rdy1    <= '0;
            e_rdy2    <= '0;
            e_sel     <= '0;
            e_done    <= '0;
            iss_valid <= '0;
            iss_idx   <= '0;
            iss_src1  <= '0;
            iss_src2  <= '0;
            iss_dst   <= '0;
            iss_pay   <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            e_valid   <= '0;
            e_rdy1    <= '0;
            e_rdy2    <= '0;
            e_sel     <= '0;
            e_done    <= '0;
            iss_valid <= '0;
            iss_idx   <= '0;
            iss_src1  <= '0;
            iss_src2  <= '0;
            iss_dst   <= '0;
            iss_pay   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && wk1[i]) e_rdy1[i] <= 1'b1;
                if (e_valid[i] && wk2[i]) e_rdy2[i] <= 1'b1;
            end
            for (int w = 0; w < NUM_WB; w++)
                if (wb_valid[w] && e_valid[wb_idx[w*IW +: IW]])
                    e_done[wb_idx[w*IW +: IW]] <= 1'b1;
            for (int p = 0; p < NUM_ISS; p++)
                if (p_vld[p])
                    e_sel[p_idx[p]] <= 1'b1;
            // Later writes win: retire clears after completion, dispatch fills after retire.
            for (int k = 0; k < RET_W; k++)
                if (ret_valid[k]) begin
                    e_valid[r_idx[k]] <= 1'b0;
                    e_rdy1[r_idx[k]]  <= 1'b0;
                    e_rdy2[r_idx[k]]  <= 1'b0;
                    e_sel[r_idx[k]]   <= 1'b0;
                    e_done[r_idx[k]]  <= 1'b0;
                end
            for (int k = 0; k < DISP_W; k++)
                if (d_acc[k]) begin
                    e_valid[d_idx[k]] <= 1'b1;
                    e_rdy1[d_idx[k]]  <= d_rdy1[k];
                    e_rdy2[d_idx[k]]  <= d_rdy2[k];
                    e_sel[d_idx[k]]   <= 1'b0;
                    e_done[d_idx[k]]  <= 1'b0;
                end
            head <= head + n_ret;
            tail <= tail + n_acc;
            for (int p = 0; p < NUM_ISS; p++)
                if (!stall[p]) begin
                    iss_valid[p] <= p_vld[p];
                    if (p_vld[p]) begin
                        iss_idx[p*IW +: IW]        <= p_idx[p];
                        iss_src1[p*TAG_W +: TAG_W] <= e_src1[p_idx[p]];
                        iss_src2[p*TAG_W +: TAG_W] <= e_src2[p_idx[p]];
                        iss_dst[p*TAG_W +: TAG_W]  <= e_dst[p_idx[p]];
                        iss_pay[p*PAY_W +: PAY_W]  <= e_pay[p_idx[p]];
                    end
                end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DISP_W; k++)
            if (d_acc[k]) begin
                e_cls[d_idx[k]]  <= disp_cls[k*CLS_W +: CLS_W];
                e_src1[d_idx[k]] <= disp_src1[k*TAG_W +: TAG_W];
                e_src2[d_idx[k]] <= disp_src2[k*TAG_W +: TAG_W];
                e_dst[d_idx[k]]  <= disp_dst[k*TAG_W +: TAG_W];
                e_pay[d_idx[k]]  <= disp_pay[k*PAY_W +: PAY_W];
            end
    end
endmodule

// File: tb/tb_issue_queue_param.sv
// tb_issue_queue_param: directed stimulus with queued expected issue/retire events checked by a negedge monitor.
module tb_issue_queue_param;
    localparam int DISP_W = 2, NUM_WB = 3, NUM_ISS = 3, RET_W = 2;
    localparam int TAG_W = 6, CLS_W = 4, PAY_W = 64, IW = 4, PW = 5;
    localparam logic [63:0] PAYB = 64'hC0DE_0000_0000_0000;
    localparam logic [3:0] ALU = 4'b0001, BU = 4'b0010;
`ifdef IQ_DISPATCH_WAKE_EN
    localparam logic [2:0] DWAKE = 3'b001;
`else
    localparam logic [2:0] DWAKE = 3'b000;
`endif

    logic clk = 1'b0;
    logic rst, flush;
    logic [DISP_W-1:0]        disp_valid, disp_rdy1, disp_rdy2;
    logic [DISP_W*CLS_W-1:0]  disp_cls;
    logic [DISP_W*TAG_W-1:0]  disp_src1, disp_src2, disp_dst;
    logic [DISP_W*PAY_W-1:0]  disp_pay;
    logic                     disp_ready;
    logic [DISP_W*IW-1:0]     disp_idx;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*TAG_W-1:0]  wb_tag;
    logic [NUM_WB*IW-1:0]     wb_idx;
    logic [NUM_ISS-1:0]       iss_valid, iss_ready;
    logic [NUM_ISS*IW-1:0]    iss_idx;
    logic [NUM_ISS*TAG_W-1:0] iss_src1, iss_src2, iss_dst;
    logic [NUM_ISS*PAY_W-1:0] iss_pay;
    logic [RET_W-1:0]         ret_valid;
    logic [RET_W*TAG_W-1:0]   ret_dst;
    logic [RET_W*PAY_W-1:0]   ret_pay;
    logic [PW-1:0]            count;

    issue_queue_param dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_cls(disp_cls), .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2), .disp_dst(disp_dst), .disp_pay(disp_pay),
        .disp_ready(disp_ready), .disp_idx(disp_idx),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_idx(wb_idx),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_idx(iss_idx), .iss_src1(iss_src1),
        .iss_src2(iss_src2), .iss_dst(iss_dst), .iss_pay(iss_pay),
        .ret_valid(ret_valid), .ret_dst(ret_dst), .ret_pay(ret_pay), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { int port; int idx; int dst; } iss_exp_t;
    iss_exp_t iss_q[$];
    int       ret_q[$];
    iss_exp_t me;
    int       mr;
    int       n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lane(input int k, input logic [3:0] cls, input int s1, input bit r1,
                        input int s2, input bit r2, input int dst);
        disp_valid[k] = 1'b1;
        disp_cls[k*CLS_W +: CLS_W]  = cls;
        disp_src1[k*TAG_W +: TAG_W] = TAG_W'(s1);
        disp_rdy1[k] = r1;
        disp_src2[k*TAG_W +: TAG_W] = TAG_W'(s2);
        disp_rdy2[k] = r2;
        disp_dst[k*TAG_W +: TAG_W]  = TAG_W'(dst);
        disp_pay[k*PAY_W +: PAY_W]  = PAYB | 64'(dst);
    endtask

    task automatic wb(input int w, input int tag, input int idx);
        wb_valid[w] = 1'b1;
        wb_tag[w*TAG_W +: TAG_W] = TAG_W'(tag);
        wb_idx[w*IW +: IW] = IW'(idx);
    endtask

    task automatic idle();
        disp_valid = '0;
        wb_valid = '0;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Monitor: every handshake on an issue port and every retire lane consumes one expected event.
    initial forever begin
        @(negedge clk);
        for (int p = 0; p < NUM_ISS; p++)
            if (iss_valid[p] && iss_ready[p]) begin
                n_cmp++;
                if (iss_q.size() == 0) begin
                    n_err++;
                    $display("FAIL iss_extra: port %0d idx %0d issued, nothing expected", p, iss_idx[p*IW +: IW]);
                end else begin
                    me = iss_q.pop_front();
                    if (p != me.port || iss_idx[p*IW +: IW] != me.idx || iss_dst[p*TAG_W +: TAG_W] != me.dst ||
                        iss_pay[p*PAY_W +: PAY_W] != (PAYB | 64'(me.dst))) begin
                        n_err++;
                        $display("FAIL iss_event: got port %0d idx %0d dst %0d pay %0h, expected port %0d idx %0d dst %0d",
                                 p, iss_idx[p*IW +: IW], iss_dst[p*TAG_W +: TAG_W], iss_pay[p*PAY_W +: PAY_W],
                                 me.port, me.idx, me.dst);
                    end
                end
            end
        for (int k = 0; k < RET_W; k++)
            if (ret_valid[k]) begin
                n_cmp++;
                if (ret_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ret_extra: lane %0d dst %0d retired, nothing expected", k, ret_dst[k*TAG_W +: TAG_W]);
                end else begin
                    mr = ret_q.pop_front();
                    if (ret_dst[k*TAG_W +: TAG_W] != mr || ret_pay[k*PAY_W +: PAY_W] != (PAYB | 64'(mr))) begin
                        n_err++;
                        $display("FAIL ret_event: lane %0d got dst %0d pay %0h, expected dst %0d",
                                 k, ret_dst[k*TAG_W +: TAG_W], ret_pay[k*PAY_W +: PAY_W], mr);
                    end
                end
            end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; iss_ready = '1;
        disp_valid = '0; disp_cls = '0; disp_src1 = '0; disp_src2 = '0; disp_rdy1 = '0; disp_rdy2 = '0;
        disp_dst = '0; disp_pay = '0; wb_valid = '0; wb_tag = '0; wb_idx = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("reset_count", count, 0);
        chk("reset_disp_ready", disp_ready, 1);
        chk("reset_iss_valid", iss_valid, 0);
        chk("reset_ret_valid", ret_valid, 0);
        chk("reset_iss_pay", iss_pay[63:0], 0);

        // Fill from empty with nothing ready.
        for (int c = 0; c < 8; c++) begin
            lane(0, ALU, 63, 0, 62, 0, 32 + 2*c);
            lane(1, ALU, 63, 0, 62, 0, 33 + 2*c);
            if (c == 0) chk("disp_idx_first", disp_idx, 8'h10);
            if (c == 7) begin
                chk("count_14", count, 14);
                chk("ready_at_14", disp_ready, 1);
                chk("disp_idx_last", disp_idx, 8'hFE);
            end
            tick();
        end
        lane(0, ALU, 63, 0, 62, 0, 40);
        chk("full_count", count, 16);
        chk("full_not_ready", disp_ready, 0);
        tick();
        chk("full_no_accept", count, 16);
        idle();

        // Complete every entry out of band; retire drains in program order.
        for (int i = 0; i < 16; i++) ret_q.push_back(32 + i);
        for (int c = 0; c < 6; c++) begin
            wb_valid = '0;
            for (int w = 0; w < NUM_WB; w++)
                if (3*c + w < 16) wb(w, 0, 3*c + w);
            tick();
        end
        wb_valid = '0;
        for (int t = 0; t < 40 && count != 0; t++) tick();
        chk("drain_count", count, 0);
        chk("drain_ready", disp_ready, 1);
        chk("tail_wrap_idx", disp_idx, 8'h10);
        chk("drain_ret_left", ret_q.size(), 0);
        do_flush();

        // Retire order: idx 1 completes before idx 0.
        lane(0, ALU, 63, 0, 63, 0, 7);
        lane(1, ALU, 63, 0, 63, 0, 8);
        tick();
        idle();
        wb(0, 0, 1);
        tick();
        idle();
        chk("ret_blocked_1", ret_valid, 0);
        tick();
        chk("ret_blocked_2", ret_valid, 0);
        ret_q.push_back(7);
        ret_q.push_back(8);
        wb(0, 0, 0);
        tick();
        idle();
        chk("ret_pair", ret_valid, 2'b11);
        chk("ret_pair_count", count, 2);
        tick();
        chk("ret_done_valid", ret_valid, 0);
        chk("ret_done_count", count, 0);
        do_flush();

        // Wakeup/select then backpressure on port 0.
        lane(0, ALU, 63, 0, 63, 0, 1);
        lane(1, ALU, 63, 0, 63, 0, 2);
        tick();
        lane(0, ALU, 63, 0, 63, 0, 3);
        lane(1, ALU, 12, 0, 0, 1, 4);
        tick();
        lane(0, ALU, 13, 0, 0, 1, 5);
        lane(1, ALU, 12, 0, 0, 1, 6);
        tick();
        idle();
        iss_q.push_back('{port: 1, idx: 5, dst: 6});
        iss_q.push_back('{port: 1, idx: 4, dst: 5});
        iss_q.push_back('{port: 0, idx: 3, dst: 4});
        wb(0, 12, 15);
        iss_ready = 3'b110;
        tick();
        chk("wake_latency", iss_valid, 3'b000);
        wb(0, 13, 15);
        tick();
        idle();
        chk("select_valid", iss_valid, 3'b011);
        chk("select_p0_idx", iss_idx[3:0], 3);
        chk("select_p1_idx", iss_idx[7:4], 5);
        tick();
        chk("bp1_valid", iss_valid, 3'b011);
        chk("bp1_p0_idx", iss_idx[3:0], 3);
        chk("bp1_p0_dst", iss_dst[5:0], 4);
        chk("bp1_p1_idx", iss_idx[7:4], 4);
        tick();
        chk("bp2_valid", iss_valid, 3'b001);
        chk("bp2_p0_idx", iss_idx[3:0], 3);
        tick();
        chk("bp3_valid", iss_valid, 3'b001);
        chk("bp3_p0_pay", iss_pay[63:0], PAYB | 64'd4);
        iss_ready = 3'b111;
        tick();
        chk("bp_release", iss_valid, 3'b000);
        chk("pre_flush_count", count, 6);
        do_flush();
        chk("flush_count", count, 0);
        chk("flush_ready", disp_ready, 1);

        // Same-cycle writeback at dispatch.
        if (DWAKE[0]) iss_q.push_back('{port: 0, idx: 0, dst: 9});
        lane(0, ALU, 9, 0, 0, 1, 9);
        wb(0, 9, 15);
        tick();
        idle();
        tick();
        chk("dispatch_wake", iss_valid, DWAKE);
        tick();
        chk("dispatch_wake_after", iss_valid, 3'b000);
        do_flush();

        // Asynchronous reset with live state.
        iss_ready = 3'b000;
        lane(0, ALU, 1, 1, 1, 1, 50);
        lane(1, ALU, 1, 1, 1, 1, 51);
        tick();
        lane(0, BU, 1, 1, 1, 1, 52);
        lane(1, ALU, 63, 0, 63, 0, 53);
        tick();
        lane(0, ALU, 63, 0, 63, 0, 54);
        lane(1, ALU, 63, 0, 63, 0, 55);
        tick();
        disp_valid = '0;
        lane(0, ALU, 63, 0, 63, 0, 56);
        tick();
        idle();
        chk("midrun_count", count, 7);
        chk("midrun_iss_valid", iss_valid, 3'b111);
        #2 rst = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_iss_valid", iss_valid, 0);
        chk("async_disp_ready", disp_ready, 1);
        chk("async_iss_dst", iss_dst, 0);
        tick();
        rst = 1'b1;
        iss_ready = 3'b111;
        tick();
        chk("post_reset_iss", iss_valid, 0);

        chk("iss_q_empty", iss_q.size(), 0);
        chk("ret_q_empty", ret_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
